// File: rtl/dice_controller.sv
// Roll-button capture for the dice game: synchronizes the raw button, detects
// its rising edge and latches the free-running die face into a stable register.
module dice_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int FACE_MIN    = 1,
    parameter int FACE_MAX    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_btn,
    input  logic [2:0] running_value,
    output logic [2:0] stored_value,
    output logic       rolled
);

    localparam logic [2:0] FACE_LO = 3'(FACE_MIN);
    localparam logic [2:0] FACE_HI = 3'(FACE_MAX);

    function automatic logic face_legal(input logic [2:0] face);
        return (face >= FACE_LO) && (face <= FACE_HI);
    endfunction

    logic btn_s;
    logic btn_prev_p1;
    logic pending;
    logic press_evt;
    logic take;

    // Button synchronizer; zero stages feeds the raw input straight to the edge detector.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign btn_s = roll_btn;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_p;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_p <= '0;
                end else begin
                    sync_p[0] <= roll_btn;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_p[i] <= sync_p[i-1];
                    end
                end
            end

            assign btn_s = sync_p[SYNC_STAGES-1];
        end
    endgenerate

    // A press seen on an illegal face is remembered until the generator shows a legal one.
    always_comb begin
        press_evt = btn_s & ~btn_prev_p1;
        take      = (press_evt | pending) & face_legal(running_value);
    end

    // Edge-detect, pending flag and the captured face.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_p1  <= 1'b0;
            pending      <= 1'b0;
            stored_value <= 3'd0;
            rolled       <= 1'b0;
        end else begin
            btn_prev_p1 <= btn_s;
            pending     <= (press_evt | pending) & ~face_legal(running_value);
            rolled      <= take;
            if (take) begin
                stored_value <= running_value;
            end
        end
    end

endmodule

// File: tb/tb_dice_controller.sv
// Randomized bench for dice_controller: a reference model predicts captures,
// a monitor compares the DUT against the predictions every cycle.
module tb_dice_controller;

    localparam int N        = 2;
    localparam int FACE_MIN = 1;
    localparam int FACE_MAX = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       roll_btn;
    logic [2:0] running_value;
    logic [2:0] stored_value;
    logic       rolled;

    int n_chk  = 0;
    int n_fail = 0;
    bit done   = 0;

    dice_controller #(
        .SYNC_STAGES(N),
        .FACE_MIN(FACE_MIN),
        .FACE_MAX(FACE_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .roll_btn(roll_btn),
        .running_value(running_value),
        .stored_value(stored_value),
        .rolled(rolled)
    );

    always #5 clk = ~clk;

    // Reference model: the synchronized button at an edge is the level that was
    // sampled N edges earlier; a rise owes one capture, paid on the first legal face.
    bit         samp_q[$];
    logic [2:0] exp_q[$];
    bit         owed        = 0;
    logic [2:0] exp_stored  = 3'd0;
    bit         exp_rolled  = 0;
    bit         lvl_now;
    bit         lvl_before;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q.delete();
            exp_q.delete();
            owed       = 0;
            exp_stored = 3'd0;
            exp_rolled = 0;
        end else begin
            samp_q.push_back(roll_btn);
            lvl_now    = (samp_q.size() > N)     ? samp_q[samp_q.size()-1-N] : 1'b0;
            lvl_before = (samp_q.size() > N + 1) ? samp_q[samp_q.size()-2-N] : 1'b0;
            if (lvl_now && !lvl_before) owed = 1;
            exp_rolled = 0;
            if (owed && int'(running_value) >= FACE_MIN && int'(running_value) <= FACE_MAX) begin
                exp_stored = running_value;
                exp_rolled = 1;
                owed       = 0;
                exp_q.push_back(running_value);
            end
            while (samp_q.size() > N + 2) void'(samp_q.pop_front());
        end
    end

    // Monitor: samples on the falling edge, pops one expected face per rolled pulse.
    logic [2:0] want;
    always @(negedge clk) begin
        if (!done) begin
            n_chk++;
            if (rolled !== exp_rolled) begin
                n_fail++;
                $display("FAIL rolled: got %b expected %b at %0t", rolled, exp_rolled, $time);
            end
            n_chk++;
            if (stored_value !== exp_stored) begin
                n_fail++;
                $display("FAIL stored_value: got %0d expected %0d at %0t", stored_value, exp_stored, $time);
            end
            if (rolled === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                n_chk++;
                if (stored_value !== want) begin
                    n_fail++;
                    $display("FAIL capture: got %0d expected %0d at %0t", stored_value, want, $time);
                end
            end
        end
    end

    task automatic cyc(input bit btn, input logic [2:0] rv);
        @(posedge clk);
        #2;
        roll_btn      = btn;
        running_value = rv;
    endtask

    task automatic legal_cycles(input bit btn, input int n);
        for (int i = 0; i < n; i++) cyc(btn, 3'($urandom_range(FACE_MIN, FACE_MAX)));
    endtask

    task automatic check_cleared(input string tag);
        n_chk++;
        if (stored_value !== 3'd0 || rolled !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got stored=%0d rolled=%b expected stored=0 rolled=0", tag, stored_value, rolled);
        end
    endtask

    task automatic async_reset(input bit btn_during, input int hold);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        roll_btn = btn_during;
        #1;
        check_cleared("async_reset");
        for (int i = 0; i < hold; i++) cyc(($urandom_range(0, 1) == 1) ? 1'b1 : btn_during, 3'd4);
        cyc(btn_during, 3'd4);
        rst_n = 1'b1;
    endtask

    bit rb;

    initial begin
        rst_n         = 1'b0;
        roll_btn      = 1'b0;
        running_value = 3'd3;

        // Reset held while the button toggles.
        for (int i = 0; i < 6; i++) cyc(i[0], 3'($urandom_range(0, 7)));
        check_cleared("in_reset");
        cyc(1'b0, 3'd5);
        rst_n = 1'b1;
        legal_cycles(1'b0, 6);
        check_cleared("idle_after_reset");

        // Single one-cycle press with face 4 at the capture edge.
        cyc(1'b1, 3'd4);
        for (int i = 0; i < 5; i++) cyc(1'b0, 3'd4);

        // Two presses separated by two low cycles, generator running.
        cyc(1'b1, 3'd1);
        legal_cycles(1'b0, 2);
        cyc(1'b1, 3'd2);
        legal_cycles(1'b0, 6);

        // Long hold gives a single capture.
        legal_cycles(1'b1, 8);
        legal_cycles(1'b0, 4);

        // Press on an illegal face: 7, 7, then 2.
        cyc(1'b1, 3'd7);
        cyc(1'b0, 3'd7);
        cyc(1'b0, 3'd7);
        cyc(1'b0, 3'd7);
        cyc(1'b0, 3'd2);
        legal_cycles(1'b0, 4);

        // Pending with a second press absorbed, faces 0.
        cyc(1'b1, 3'd0);
        cyc(1'b0, 3'd0);
        cyc(1'b1, 3'd0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'd0);
        cyc(1'b0, 3'd6);
        legal_cycles(1'b0, 4);

        // Back-to-back presses.
        cyc(1'b1, 3'd3);
        cyc(1'b0, 3'd3);
        cyc(1'b1, 3'd5);
        legal_cycles(1'b0, 5);

        // Reset while pending, button still high after release.
        cyc(1'b1, 3'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'd7);
        async_reset(1'b1, 2);
        legal_cycles(1'b1, 6);
        legal_cycles(1'b0, 3);

        // Reset while the button is held mid-capture.
        legal_cycles(1'b1, 2);
        async_reset(1'b1, 1);
        legal_cycles(1'b1, 5);
        legal_cycles(1'b0, 3);

        // Random run: button runs of random length, faces over the full 3-bit range.
        rb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 35) rb = ~rb;
            cyc(rb, 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 299) == 0) async_reset(rb, 1);
        end
        legal_cycles(1'b0, 8);

        @(negedge clk);
        #1;
        done = 1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_captures: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
